// File: rtl/aukv_lsu.sv
// ----------------------------------------------------------------------------
// aukv_lsu -- load/store and write-back staging unit (RV32I, 5-stage pipe)
//
// Takes the execute-stage ALU result either as a pass-through rd value or as
// the effective address of a load/store. Memory ops run one outstanding
// req/ack transaction on the data bus with byte-lane steering, load sign/zero
// extension and alignment checking. Results are registered toward write-back.
//
// Ports
//   i_clk, i_rstn           clock (rising edge), async active-low reset
//   i_valid                 execute stage presents an instruction
//   i_load / i_store        instruction class (mutually exclusive)
//   i_funct3                access width/sign (B, H, W, BU, HU)
//   i_alu_result            effective address, or rd value for non-mem ops
//   i_store_data            rs2 value for stores
//   i_rd                    destination register index
//   o_stall                 unit busy, upstream holds its instruction
//   o_dmem_*                data bus request (held until i_dmem_ack)
//   i_dmem_ack/i_dmem_rdata bus completion and read word
//   o_wb_*                  one-cycle retire toward the register file
//   o_fault                 one-cycle pulse: misaligned or illegal mem op
// ----------------------------------------------------------------------------
module aukv_lsu (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_fault
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state, state_nxt;

    // Transaction context captured at accept time.
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        store_q;

    logic        is_mem;
    logic        illegal, misaligned;
    logic        accept_alu, accept_fault, accept_mem, done;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign is_mem = i_load | i_store;

    // ------------------------------------------------------------------
    // Next-state and accept decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt    = state;
        accept_alu   = 1'b0;
        accept_fault = 1'b0;
        accept_mem   = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        misaligned   = 1'b0;
        be_calc      = 4'b0000;
        wdata_calc   = i_store_data;

        unique case (i_funct3)
            F3_B, F3_BU: begin
                be_calc    = 4'b0001 << i_alu_result[1:0];
                wdata_calc = {4{i_store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be_calc    = 4'b0011 << i_alu_result[1:0];
                wdata_calc = {2{i_store_data[15:0]}};
                misaligned = i_alu_result[0];
            end
            F3_W: begin
                be_calc    = 4'b1111;
                misaligned = |i_alu_result[1:0];
            end
            default: illegal = 1'b1;
        endcase

        // Unsigned variants only exist for loads.
        if (i_store && (i_funct3 == F3_BU || i_funct3 == F3_HU))
            illegal = 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (!is_mem) begin
                        accept_alu = 1'b1;
                    end else if (illegal || misaligned) begin
                        accept_fault = 1'b1;
                    end else begin
                        accept_mem = 1'b1;
                        state_nxt  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Upstream inputs are ignored here; it holds them under stall.
                if (i_dmem_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension from the registered address
    // ------------------------------------------------------------------
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    byte_sel = i_dmem_rdata[7:0];
            2'd1:    byte_sel = i_dmem_rdata[15:8];
            2'd2:    byte_sel = i_dmem_rdata[23:16];
            default: byte_sel = i_dmem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

        unique case (funct3_q)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            default: load_val = i_dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!i_rstn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Bus request context and write-back registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_q       <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            store_q      <= 1'b0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_rd      <= '0;
            o_wb_data    <= '0;
            o_fault      <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            o_fault    <= 1'b0;

            if (accept_alu) begin
                o_wb_valid <= 1'b1;
                o_wb_we    <= (i_rd != 5'd0);
                o_wb_rd    <= i_rd;
                o_wb_data  <= i_alu_result;
            end

            if (accept_fault)
                o_fault <= 1'b1;

            if (accept_mem) begin
                addr_q       <= i_alu_result;
                funct3_q     <= i_funct3;
                rd_q         <= i_rd;
                store_q      <= i_store;
                o_dmem_be    <= be_calc;
                o_dmem_wdata <= i_store ? wdata_calc : 32'h0;
            end

            if (done) begin
                o_wb_valid <= 1'b1;
                o_wb_rd    <= rd_q;
                if (store_q) begin
                    o_wb_we   <= 1'b0;
                    o_wb_data <= 32'h0;
                end else begin
                    o_wb_we   <= (rd_q != 5'd0);
                    o_wb_data <= load_val;
                end
            end
        end
    end

    // Request and stall derive straight from the state register, so reset
    // drops them immediately.
    assign o_stall     = (state == ST_WAIT);
    assign o_dmem_req  = (state == ST_WAIT);
    assign o_dmem_we   = store_q;
    assign o_dmem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_aukv_lsu.sv
// ----------------------------------------------------------------------------
// tb_aukv_lsu -- self-checking bench for aukv_lsu.
// Directed scenarios from the unit's behaviour plus a randomized mix, all
// checked against a behavioural model of the load/store rules. Inputs are
// driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_aukv_lsu;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    int checks = 0;
    int errors = 0;

    aukv_lsu dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_valid      (valid),
        .i_load       (load),
        .i_store      (store),
        .i_funct3     (funct3),
        .i_alu_result (alu_result),
        .i_store_data (store_data),
        .i_rd         (rd),
        .o_stall      (stall),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_be    (dmem_be),
        .o_dmem_wdata (dmem_wdata),
        .i_dmem_ack   (dmem_ack),
        .i_dmem_rdata (dmem_rdata),
        .o_wb_valid   (wb_valid),
        .o_wb_we      (wb_we),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data),
        .o_fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: access rules computed with plain arithmetic
    // ------------------------------------------------------------------
    function automatic bit m_fault(input bit ld, input bit st, input int f3, input longint a);
        bit ill, mis;
        ill = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && (f3 == 4 || f3 == 5));
        mis = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
        return (ld || st) && (ill || mis);
    endfunction

    function automatic logic [3:0] m_be(input int f3, input longint a);
        int sz;
        sz = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 3 : 15;
        if (sz == 15) return 4'hF;
        return 4'(sz * (2 ** (a % 4)));
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input longint d);
        if (f3 == 0) return 32'((d % 256) * 32'h0101_0101);
        if (f3 == 1) return 32'((d % 65536) * 32'h0001_0001);
        return 32'(d);
    endfunction

    function automatic logic [31:0] m_load(input int f3, input longint a, input longint w);
        longint v;
        if (f3 == 0 || f3 == 4) begin
            v = (w / (256 ** (a % 4))) % 256;
            if (f3 == 0 && v >= 128) v = v - 256;
        end else if (f3 == 1 || f3 == 5) begin
            v = (w / (65536 ** ((a % 4) / 2))) % 65536;
            if (f3 == 1 && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return 32'(v);
    endfunction

    task automatic drive_idle();
        valid      = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        funct3     = 3'b000;
        alu_result = 32'h0;
        store_data = 32'h0;
        rd         = 5'd0;
    endtask

    // ------------------------------------------------------------------
    // One complete instruction: present, check issue, ack, check retire
    // ------------------------------------------------------------------
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic [31:0] rw, input int delay);
        bit          f;
        logic [31:0] exp_data;
        f = m_fault(ld, st, int'(f3), longint'(a));

        @(negedge clk);
        valid = 1'b1; load = ld; store = st; funct3 = f3;
        alu_result = a; store_data = sd; rd = r;
        @(negedge clk);
        drive_idle();

        if (!ld && !st) begin
            checks++;
            if ({wb_valid, wb_we, wb_rd, wb_data, fault, stall} !== {1'b1, (r != 0), r, a, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL alu_wb: got v=%b we=%b rd=%0d d=%h f=%b s=%b expected v=1 we=%b rd=%0d d=%h f=0 s=0",
                         wb_valid, wb_we, wb_rd, wb_data, fault, stall, (r != 0), r, a);
            end
        end else if (f) begin
            checks++;
            if ({fault, wb_valid, dmem_req, stall} !== 4'b1000) begin
                errors++;
                $display("FAIL fault_pulse: got fault=%b wbv=%b req=%b stall=%b expected 1 0 0 0 (f3=%0d a=%h st=%b)",
                         fault, wb_valid, dmem_req, stall, f3, a, st);
            end
        end else begin
            checks++;
            if ({dmem_req, stall, dmem_we, dmem_addr, dmem_be, wb_valid} !==
                {1'b1, 1'b1, st, a & 32'hFFFF_FFFC, m_be(int'(f3), longint'(a)), 1'b0}) begin
                errors++;
                $display("FAIL issue: got req=%b stall=%b we=%b addr=%h be=%b wbv=%b expected 1 1 %b %h %b 0",
                         dmem_req, stall, dmem_we, dmem_addr, dmem_be, wb_valid,
                         st, a & 32'hFFFF_FFFC, m_be(int'(f3), longint'(a)));
            end
            if (st) begin
                checks++;
                if (dmem_wdata !== m_wdata(int'(f3), longint'(sd))) begin
                    errors++;
                    $display("FAIL store_wdata: got %h expected %h", dmem_wdata, m_wdata(int'(f3), longint'(sd)));
                end
            end
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                checks++;
                if ({dmem_req, stall, wb_valid, dmem_addr} !== {1'b1, 1'b1, 1'b0, a & 32'hFFFF_FFFC}) begin
                    errors++;
                    $display("FAIL wait_hold: got req=%b stall=%b wbv=%b addr=%h expected 1 1 0 %h",
                             dmem_req, stall, wb_valid, dmem_addr, a & 32'hFFFF_FFFC);
                end
            end
            dmem_ack = 1'b1; dmem_rdata = rw;
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            exp_data = st ? 32'h0 : m_load(int'(f3), longint'(a), longint'(rw));
            checks++;
            if ({wb_valid, wb_we, wb_rd, wb_data, dmem_req, stall, fault} !==
                {1'b1, (!st && r != 0), r, exp_data, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL mem_retire: got v=%b we=%b rd=%0d d=%h req=%b s=%b f=%b expected 1 %b %0d %h 0 0 0",
                         wb_valid, wb_we, wb_rd, wb_data, dmem_req, stall, fault, (!st && r != 0), r, exp_data);
            end
        end

        // Both pulses must be exactly one cycle long.
        @(negedge clk);
        checks++;
        if ({wb_valid, fault, stall} !== 3'b000) begin
            errors++;
            $display("FAIL single_pulse: got wbv=%b fault=%b stall=%b expected 0 0 0", wb_valid, fault, stall);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        drive_idle();
        #12;
        checks++;
        if ({stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b stall=%b addr=%h wbv=%b fault=%b expected all zero",
                     dmem_req, stall, dmem_addr, wb_valid, fault);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_alu();
        do_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 32'h0, 0);
        do_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 32'h0, 0);
    endtask

    task automatic test_store_byte();
        do_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CC9F, 5'd7, 32'h0, 3);
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1122_3344, 5'd0, 32'h0, 1);
        do_op(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 5'd1, 32'h0, 0);
    endtask

    task automatic test_loads();
        do_op(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 5'd3, 32'h0080_0000, 1);
        do_op(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 5'd3, 32'h0080_0000, 0);
        do_op(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd4, 32'h8001_0000, 2);
        do_op(1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'h0, 5'd4, 32'h8001_F00D, 0);
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 5'd0, 32'hCAFE_F00D, 0);
    endtask

    task automatic test_faults();
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd2, 32'h0, 0);
        do_op(1'b0, 1'b1, 3'b100, 32'h0000_3000, 32'h0, 5'd2, 32'h0, 0);
        do_op(1'b1, 1'b0, 3'b001, 32'h0000_3003, 32'h0, 5'd2, 32'h0, 0);
        do_op(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd2, 32'h0, 0);
    endtask

    // LW acked at N+1 with an ALU op held upstream during the stall.
    task automatic test_back_to_back();
        @(negedge clk);
        valid = 1'b1; load = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_4008; rd = 5'd9;
        @(negedge clk);
        // Upstream now presents the next instruction and holds it.
        load = 1'b0; alu_result = 32'h0BAD_CAFE; rd = 5'd10;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({wb_valid, wb_rd, wb_data, stall} !== {1'b1, 5'd9, 32'h5555_AAAA, 1'b0}) begin
            errors++;
            $display("FAIL b2b_load: got v=%b rd=%0d d=%h s=%b expected 1 9 5555aaaa 0", wb_valid, wb_rd, wb_data, stall);
        end
        @(negedge clk);
        drive_idle();
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd10, 32'h0BAD_CAFE}) begin
            errors++;
            $display("FAIL b2b_alu: got v=%b rd=%0d d=%h expected 1 10 0badcafe", wb_valid, wb_rd, wb_data);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_dup: got wbv=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        valid = 1'b1; load = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_5000; rd = 5'd6;
        @(negedge clk);
        drive_idle();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({dmem_req, stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: got req=%b stall=%b expected 0 0", dmem_req, stall);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({wb_valid, dmem_req, stall} !== 3'b000) begin
            errors++;
            $display("FAIL stale_ack: got wbv=%b req=%b stall=%b expected 0 0 0", wb_valid, dmem_req, stall);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a    = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), a, $urandom,
                  5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_byte();
        test_loads();
        test_faults();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
